// File: rtl/input_tracker.sv
// input_tracker: in-order 20-bit address queue exposing its eight oldest entries.
// Define INPUT_TRACKER_ZERO_FILL_EN to force window slots beyond count to 0.
module input_tracker #(
    parameter int DEPTH = 256,
    parameter int AW    = 20
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [AW-1:0] din,
    input  logic          read,
    input  logic          write,
    output logic [AW-1:0] d0_addr,
    output logic [AW-1:0] d1_addr,
    output logic [AW-1:0] d2_addr,
    output logic [AW-1:0] d3_addr,
    output logic [AW-1:0] d4_addr,
    output logic [AW-1:0] d5_addr,
    output logic [AW-1:0] d6_addr,
    output logic [AW-1:0] d7_addr
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

    logic [AW-1:0] mem_q [DEPTH];
    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [PW:0]   count_q, count_d;
    logic          rd_ok, wr_ok;
    logic [AW-1:0] win [8];

    // An accepted pop frees a slot for a same-cycle write when full.
    assign rd_ok = read && (count_q != '0);
    assign wr_ok = write && ((count_q != FULL) || rd_ok);

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (rd_ok) begin
            head_d = head_q + 1'b1;
        end
        if (wr_ok) begin
            tail_d = tail_q + 1'b1;
        end
        unique case ({rd_ok, wr_ok})
            2'b10:   count_d = count_q - 1'b1;
            2'b01:   count_d = count_q + 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Storage is never cleared; reset only blocks the write.
    always_ff @(posedge clk) begin
        if (!rst_n && wr_ok) begin
            mem_q[tail_q] <= din;
        end
    end

    always_comb begin
        for (int k = 0; k < 8; k++) begin
            win[k] = mem_q[head_q + PW'(k)];
`ifdef INPUT_TRACKER_ZERO_FILL_EN
            if (count_q <= (PW+1)'(k)) begin
                win[k] = '0;
            end
`endif
        end
    end

    assign d0_addr = win[0];
    assign d1_addr = win[1];
    assign d2_addr = win[2];
    assign d3_addr = win[3];
    assign d4_addr = win[4];
    assign d5_addr = win[5];
    assign d6_addr = win[6];
    assign d7_addr = win[7];

endmodule

// File: tb/tb_input_tracker.sv
// Bench for input_tracker: queue scoreboard plus storage model for stale slots.
module tb_input_tracker;

    localparam int D = 256;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [19:0] din = '0;
    logic        read = 1'b0;
    logic        write = 1'b0;
    logic [19:0] dout [8];

    int checks = 0;
    int errors = 0;

    logic [19:0] q [$];
    logic [19:0] mm [D];
    bit          known [D];
    int          hp = 0;

    always #5 clk = ~clk;

    input_tracker #(.DEPTH(D), .AW(20)) dut (
        .clk(clk), .rst_n(rst_n), .din(din), .read(read), .write(write),
        .d0_addr(dout[0]), .d1_addr(dout[1]), .d2_addr(dout[2]),
        .d3_addr(dout[3]), .d4_addr(dout[4]), .d5_addr(dout[5]),
        .d6_addr(dout[6]), .d7_addr(dout[7])
    );

    function automatic void exp_slot(input int k, output logic [19:0] e,
                                     output bit v);
        int idx;
        idx = (hp + k) % D;
        if (k < q.size()) begin
            e = q[k];
            v = 1'b1;
        end else begin
`ifdef INPUT_TRACKER_ZERO_FILL_EN
            e = '0;
            v = 1'b1;
`else
            e = mm[idx];
            v = known[idx];
`endif
        end
    endfunction

    task automatic step(input bit r, input bit w, input logic [19:0] d,
                        input bit rs = 1'b0);
        bit rok, wok;
        int tl;
        rst_n = rs;
        read  = r;
        write = w;
        din   = d;
        @(posedge clk);
        if (rs) begin
            q.delete();
            hp = 0;
        end else begin
            rok = r && (q.size() > 0);
            wok = w && ((q.size() < D) || rok);
            tl  = (hp + q.size()) % D;
            if (wok) begin
                mm[tl] = d;
                known[tl] = 1'b1;
            end
            if (rok) begin
                void'(q.pop_front());
                hp = (hp + 1) % D;
            end
            if (wok) q.push_back(d);
        end
        #1;
        rst_n = 1'b0;
        read  = 1'b0;
        write = 1'b0;
    endtask

    task automatic test_reset();
        logic [19:0] e;
        bit v;
        step(0, 0, 0, 1);
        step(1, 0, 0);
        for (int k = 0; k < 8; k++) begin
            exp_slot(k, e, v);
            if (v) begin
                checks++;
                if (dout[k] !== e) begin
                    errors++;
                    $display("FAIL reset slot%0d got %h exp %h", k, dout[k], e);
                end
            end
        end
    endtask

    task automatic test_fill();
        logic [19:0] e;
        bit v;
        for (int n = 1; n <= 256; n++) begin
            step(0, 1, 20'(n));
            for (int k = 0; k < 8; k++) begin
                exp_slot(k, e, v);
                if (v && (n == 1 || n == 256)) begin
                    checks++;
                    if (dout[k] !== e) begin
                        errors++;
                        $display("FAIL fill n%0d slot%0d got %h exp %h",
                                 n, k, dout[k], e);
                    end
                end
            end
        end
        checks++;
        if (dout[0] !== 20'd1) begin
            errors++;
            $display("FAIL fill_head got %h exp 1", dout[0]);
        end
        step(0, 1, 20'd999);
        for (int k = 0; k < 8; k++) begin
            checks++;
            if (dout[k] !== 20'(k + 1)) begin
                errors++;
                $display("FAIL fill_drop slot%0d got %h exp %h",
                         k, dout[k], k + 1);
            end
        end
    endtask

    task automatic test_partial_drain();
        for (int n = 0; n < 128; n++) step(1, 0, 0);
        for (int k = 0; k < 8; k++) begin
            checks++;
            if (dout[k] !== 20'(129 + k)) begin
                errors++;
                $display("FAIL drain128 slot%0d got %h exp %h",
                         k, dout[k], 129 + k);
            end
        end
    endtask

    task automatic test_overfill();
        for (int n = 1; n <= 512; n++) step(0, 1, 20'(n));
        for (int k = 0; k < 8; k++) begin
            checks++;
            if (dout[k] !== 20'(129 + k)) begin
                errors++;
                $display("FAIL overfill slot%0d got %h exp %h",
                         k, dout[k], 129 + k);
            end
        end
        for (int n = 0; n < 128; n++) step(1, 0, 0);
        for (int k = 0; k < 8; k++) begin
            checks++;
            if (dout[k] !== 20'(k + 1)) begin
                errors++;
                $display("FAIL overfill_drain slot%0d got %h exp %h",
                         k, dout[k], k + 1);
            end
        end
    endtask

    task automatic test_drain_empty();
        logic [19:0] e;
        bit v;
        for (int n = 0; n < 125; n++) step(1, 0, 0);
        for (int k = 0; k < 8; k++) begin
            exp_slot(k, e, v);
            if (k < 3) e = 20'(126 + k);
            if (v || k < 3) begin
                checks++;
                if (dout[k] !== e) begin
                    errors++;
                    $display("FAIL drain125 slot%0d got %h exp %h",
                             k, dout[k], e);
                end
            end
        end
        for (int n = 0; n < 8; n++) step(1, 0, 0);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL model_empty got %0d exp 0", q.size());
        end
        for (int k = 0; k < 8; k++) begin
            exp_slot(k, e, v);
            if (v) begin
                checks++;
                if (dout[k] !== e) begin
                    errors++;
                    $display("FAIL empty slot%0d got %h exp %h", k, dout[k], e);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [19:0] e;
        bit v;
        step(1, 1, 20'h11);
        checks++;
        if (dout[0] !== 20'h11) begin
            errors++;
            $display("FAIL empty_rw got %h exp 00011", dout[0]);
        end
        for (int n = 0; n < 255; n++) step(0, 1, 20'(1000 + n));
        step(1, 1, 20'hABCDE);
        checks++;
        if (dout[0] !== 20'd1000 || q.size() != D) begin
            errors++;
            $display("FAIL full_rw got %h exp %h", dout[0], 20'd1000);
        end
        for (int n = 0; n < 255; n++) step(1, 0, 0);
        checks++;
        if (dout[0] !== 20'hABCDE) begin
            errors++;
            $display("FAIL newest got %h exp abcde", dout[0]);
        end
        step(0, 1, 20'h5, 1);
        for (int k = 0; k < 8; k++) begin
            exp_slot(k, e, v);
            if (v) begin
                checks++;
                if (dout[k] !== e) begin
                    errors++;
                    $display("FAIL rst_wr slot%0d got %h exp %h", k, dout[k], e);
                end
            end
        end
        step(0, 1, 20'h7);
        for (int k = 0; k < 8; k++) begin
            exp_slot(k, e, v);
            if (v) begin
                checks++;
                if (dout[k] !== e) begin
                    errors++;
                    $display("FAIL post_rst slot%0d got %h exp %h",
                             k, dout[k], e);
                end
            end
        end
        checks++;
        if (dout[0] !== 20'h7) begin
            errors++;
            $display("FAIL post_rst_head got %h exp 00007", dout[0]);
        end
    endtask

    initial begin
        for (int i = 0; i < D; i++) known[i] = 1'b0;
        #2;
        test_reset();
        test_fill();
        test_partial_drain();
        test_overfill();
        test_drain_empty();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
